// File: rtl/lbdr_dr_router.sv
// lbdr_dr_router
//   LBDR routing unit with deroute support for one input port of a 2D-mesh
//   NoC router. A header flit is routed to a single output port. The decision
//   is held until the tail flit is granted.
//
// Ports
//   clk, rst        clock; synchronous active-high reset that also loads config
//   Rxy_rst[7:0]    routing bits {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}
//   Cx_rst[3:0]     connectivity {Cs,Cw,Ce,Cn}
//   dr_rst[7:0]     deroute port per direction: N[1:0] E[3:2] W[5:4] S[7:6]
//   cur_addr_rst    this router's address {y, x}
//   flit_valid      input FIFO presents a flit
//   flit_id[2:0]    type of the presented flit
//   dst_addr        destination address {y, x} (header only)
//   grant           allocator accepted the presented flit
//   N/E/W/S/Lport   registered one-hot port request
//   routed          packet route held
//   err_unroutable  pulse: header had no usable port
//   err_proto       pulse: flit-type sequence violation
module lbdr_dr_router #(
  parameter int          XW         = 2,
  parameter int          YW         = 2,
  parameter logic [2:0]  HEADER_ID  = 3'b001,
  parameter logic [2:0]  PAYLOAD_ID = 3'b010,
  parameter logic [2:0]  TAIL_ID    = 3'b100,
  localparam int         AW         = XW + YW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    Rxy_rst,
  input  logic [3:0]    Cx_rst,
  input  logic [7:0]    dr_rst,
  input  logic [AW-1:0] cur_addr_rst,
  input  logic          flit_valid,
  input  logic [2:0]    flit_id,
  input  logic [AW-1:0] dst_addr,
  input  logic          grant,
  output logic          Nport,
  output logic          Eport,
  output logic          Wport,
  output logic          Sport,
  output logic          Lport,
  output logic          routed,
  output logic          err_unroutable,
  output logic          err_proto
);

  typedef enum logic {IDLE, ROUTED} state_t;

  // Port vector index: 0=N 1=E 2=W 3=S 4=L (N..S match Cx and dr encodings)
  state_t          state_q, state_d;
  logic [4:0]      port_q, port_d;
  logic            err_u_q, err_u_d;
  logic            err_p_q, err_p_d;
  logic [7:0]      rxy_q, rxy_d;
  logic [3:0]      cx_q, cx_d;
  logic [7:0]      dr_q, dr_d;
  logic [AW-1:0]   cur_q, cur_d;

  logic [XW-1:0]   x_cur, x_dst;
  logic [YW-1:0]   y_cur, y_dst;
  logic            n1, s1, e1, w1, local_hit;
  logic [3:0]      cand;
  logic [1:0]      alt_dir;
  logic [4:0]      route_sel;
  logic            route_ok;
  logic            is_hdr, is_tail, is_pay;

  assign x_cur = cur_q[XW-1:0];
  assign y_cur = cur_q[AW-1:XW];
  assign x_dst = dst_addr[XW-1:0];
  assign y_dst = dst_addr[AW-1:XW];

  assign n1 = y_dst < y_cur;
  assign s1 = y_cur < y_dst;
  assign e1 = x_cur < x_dst;
  assign w1 = x_dst < x_cur;
  assign local_hit = ~n1 & ~e1 & ~w1 & ~s1;

  assign cand[0] = ((n1 & ~e1 & ~w1) | (n1 & e1 & rxy_q[0]) | (n1 & w1 & rxy_q[1])) & cx_q[0];
  assign cand[1] = ((e1 & ~n1 & ~s1) | (e1 & n1 & rxy_q[2]) | (e1 & s1 & rxy_q[3])) & cx_q[1];
  assign cand[2] = ((w1 & ~n1 & ~s1) | (w1 & n1 & rxy_q[4]) | (w1 & s1 & rxy_q[5])) & cx_q[2];
  assign cand[3] = ((s1 & ~e1 & ~w1) | (s1 & e1 & rxy_q[6]) | (s1 & w1 & rxy_q[7])) & cx_q[3];

  // Header and tail are matched by bit so a single-flit packet (both bits
  // set) counts as both.
  assign is_hdr  = flit_valid & ((flit_id & HEADER_ID) == HEADER_ID);
  assign is_tail = flit_valid & ((flit_id & TAIL_ID) == TAIL_ID);
  assign is_pay  = flit_valid & (flit_id == PAYLOAD_ID);

  // Route selection: local, then minimal N>E>W>S, then deroute taken from
  // the first productive direction's dr field if that port is connected.
  always_comb begin
    route_sel = '0;
    route_ok  = 1'b0;
    alt_dir   = '0;
    if (n1)      alt_dir = dr_q[1:0];
    else if (e1) alt_dir = dr_q[3:2];
    else if (w1) alt_dir = dr_q[5:4];
    else         alt_dir = dr_q[7:6];

    if (local_hit) begin
      route_sel[4] = 1'b1;
      route_ok     = 1'b1;
    end else if (cand[0]) begin
      route_sel[0] = 1'b1;
      route_ok     = 1'b1;
    end else if (cand[1]) begin
      route_sel[1] = 1'b1;
      route_ok     = 1'b1;
    end else if (cand[2]) begin
      route_sel[2] = 1'b1;
      route_ok     = 1'b1;
    end else if (cand[3]) begin
      route_sel[3] = 1'b1;
      route_ok     = 1'b1;
    end else if (cx_q[alt_dir]) begin
      route_sel[{1'b0, alt_dir}] = 1'b1;
      route_ok                   = 1'b1;
    end
  end

  always_comb begin
    rxy_d = rst ? Rxy_rst      : rxy_q;
    cx_d  = rst ? Cx_rst       : cx_q;
    dr_d  = rst ? dr_rst       : dr_q;
    cur_d = rst ? cur_addr_rst : cur_q;
  end

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    err_u_d = 1'b0;
    err_p_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_hdr) begin
          if (route_ok) begin
            port_d  = route_sel;
            state_d = ROUTED;
          end else begin
            err_u_d = 1'b1;
          end
        end else if (is_pay | is_tail) begin
          err_p_d = 1'b1;
        end
      end
      ROUTED: begin
        // A granted tail closes the packet; a single-flit packet still
        // waiting for its grant is not a protocol error.
        if (is_tail & grant) begin
          port_d  = '0;
          state_d = IDLE;
        end else if (is_hdr & ~is_tail) begin
          err_p_d = 1'b1;
          if (route_ok) begin
            port_d = route_sel;
          end else begin
            err_u_d = 1'b1;
            port_d  = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        port_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    rxy_q <= rxy_d;
    cx_q  <= cx_d;
    dr_q  <= dr_d;
    cur_q <= cur_d;
    if (rst) begin
      state_q <= IDLE;
      port_q  <= '0;
      err_u_q <= 1'b0;
      err_p_q <= 1'b0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      err_u_q <= err_u_d;
      err_p_q <= err_p_d;
    end
  end

  assign Nport          = port_q[0];
  assign Eport          = port_q[1];
  assign Wport          = port_q[2];
  assign Sport          = port_q[3];
  assign Lport          = port_q[4];
  assign routed         = (state_q == ROUTED);
  assign err_unroutable = err_u_q;
  assign err_proto      = err_p_q;

endmodule

// File: tb/tb_lbdr_dr_router.sv
module tb_lbdr_dr_router;

  logic       clk;
  logic       rst;
  logic [7:0] rxy_rst;
  logic [3:0] cx_rst;
  logic [7:0] dr_rst;
  logic [3:0] cur2_rst;
  logic [5:0] cur3_rst;
  logic       fv;
  logic [2:0] fid;
  logic [3:0] dst2;
  logic [5:0] dst3;
  logic       grant;

  logic n2, e2, w2, s2, l2, r2, eu2, ep2;
  logic n3, e3, w3, s3, l3, r3, eu3, ep3;
  logic [7:0] obs2, obs3;

  assign obs2 = {l2, s2, w2, e2, n2, r2, eu2, ep2};
  assign obs3 = {l3, s3, w3, e3, n3, r3, eu3, ep3};

  lbdr_dr_router #(.XW(2), .YW(2)) u_d2 (
    .clk(clk), .rst(rst), .Rxy_rst(rxy_rst), .Cx_rst(cx_rst), .dr_rst(dr_rst),
    .cur_addr_rst(cur2_rst), .flit_valid(fv), .flit_id(fid), .dst_addr(dst2),
    .grant(grant), .Nport(n2), .Eport(e2), .Wport(w2), .Sport(s2), .Lport(l2),
    .routed(r2), .err_unroutable(eu2), .err_proto(ep2)
  );

  lbdr_dr_router #(.XW(3), .YW(3)) u_d3 (
    .clk(clk), .rst(rst), .Rxy_rst(rxy_rst), .Cx_rst(cx_rst), .dr_rst(dr_rst),
    .cur_addr_rst(cur3_rst), .flit_valid(fv), .flit_id(fid), .dst_addr(dst3),
    .grant(grant), .Nport(n3), .Eport(e3), .Wport(w3), .Sport(s3), .Lport(l3),
    .routed(r3), .err_unroutable(eu3), .err_proto(ep3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  string cur_tag = "init";

  // Reference model: route held as a port index (-1 = idle), config as plain values
  logic [7:0] m_rxy, m_dr;
  logic [3:0] m_cx;
  int m_cur[2];
  int m_port[2];
  bit m_eu[2], m_ep[2];

  // Returns 0=N 1=E 2=W 3=S 4=L, or -1 when unroutable.
  function automatic int model_route(int w, int cur, int dst);
    int cx, cy, dx, dy;
    bit go[4];
    bit ok[4];
    int alt;
    cx = cur & ((1 << w) - 1);
    cy = cur >> w;
    dx = dst & ((1 << w) - 1);
    dy = dst >> w;
    go[0] = dy < cy;
    go[1] = dx > cx;
    go[2] = dx < cx;
    go[3] = dy > cy;
    if (!(go[0] || go[1] || go[2] || go[3])) return 4;
    ok[0] = go[0] && (!(go[1] || go[2]) || (go[1] ? m_rxy[0] : m_rxy[1])) && m_cx[0];
    ok[1] = go[1] && (!(go[0] || go[3]) || (go[0] ? m_rxy[2] : m_rxy[3])) && m_cx[1];
    ok[2] = go[2] && (!(go[0] || go[3]) || (go[0] ? m_rxy[4] : m_rxy[5])) && m_cx[2];
    ok[3] = go[3] && (!(go[1] || go[2]) || (go[1] ? m_rxy[6] : m_rxy[7])) && m_cx[3];
    for (int d = 0; d < 4; d++) if (ok[d]) return d;
    for (int d = 0; d < 4; d++) begin
      if (go[d]) begin
        alt = (int'(m_dr) >> (2 * d)) & 3;
        if (m_cx[alt]) return alt;
        return -1;
      end
    end
    return -1;
  endfunction

  function automatic logic [7:0] model_pack(int port, bit eu, bit ep);
    logic [4:0] oh;
    oh = (port >= 0) ? 5'(1 << port) : 5'd0;
    return {oh, port >= 0, eu, ep};
  endfunction

  task automatic model_update();
    int r;
    bit hdr, tail, pay;
    if (rst) begin
      m_rxy = rxy_rst; m_cx = cx_rst; m_dr = dr_rst;
      m_cur[0] = int'(cur2_rst); m_cur[1] = int'(cur3_rst);
      for (int k = 0; k < 2; k++) begin
        m_port[k] = -1; m_eu[k] = 0; m_ep[k] = 0;
      end
      return;
    end
    hdr  = fv && fid[0];
    tail = fv && fid[2];
    pay  = fv && (fid == 3'b010);
    for (int k = 0; k < 2; k++) begin
      m_eu[k] = 0;
      m_ep[k] = 0;
      r = (k == 0) ? model_route(2, m_cur[0], int'(dst2)) : model_route(3, m_cur[1], int'(dst3));
      if (m_port[k] < 0) begin
        if (hdr) begin
          if (r < 0) m_eu[k] = 1;
          else m_port[k] = r;
        end else if (pay || tail) begin
          m_ep[k] = 1;
        end
      end else begin
        if (tail && grant) begin
          m_port[k] = -1;
        end else if (hdr && !tail) begin
          m_ep[k] = 1;
          if (r < 0) begin
            m_eu[k] = 1;
            m_port[k] = -1;
          end else begin
            m_port[k] = r;
          end
        end
      end
    end
  endtask

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s observed=%b expected=%b", cur_tag, tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("model_d2", obs2, model_pack(m_port[0], m_eu[0], m_ep[0]));
    check("model_d3", obs3, model_pack(m_port[1], m_eu[1], m_ep[1]));
  endtask

  task automatic drive(logic v, logic [2:0] id, logic g, logic [3:0] a2, logic [5:0] a3);
    fv = v; fid = id; grant = g; dst2 = a2; dst3 = a3;
  endtask

  task automatic do_reset(logic [7:0] rxy, logic [3:0] cx, logic [7:0] dr,
                          logic [3:0] c2, logic [5:0] c3);
    rst = 1'b1; rxy_rst = rxy; cx_rst = cx; dr_rst = dr; cur2_rst = c2; cur3_rst = c3;
    step();
    rst = 1'b0;
  endtask

  localparam logic [2:0] HDR = 3'b001, PAY = 3'b010, TL = 3'b100, SGL = 3'b101;

  initial begin
    logic [2:0] ids [5];
    ids[0] = 3'b000; ids[1] = HDR; ids[2] = PAY; ids[3] = TL; ids[4] = SGL;
    drive(1'b0, 3'b000, 1'b0, 4'h0, 6'o00);

    cur_tag = "reset";
    do_reset(8'h3C, 4'hF, 8'h00, 4'h5, 6'o33);
    check("reset_d2", obs2, 8'h00);
    check("reset_d3", obs3, 8'h00);

    cur_tag = "south";
    drive(1'b1, HDR, 1'b0, 4'h9, 6'o73);
    step();
    check("south_d2", obs2, 8'b01000_100);
    check("south_d3", obs3, 8'b01000_100);
    drive(1'b1, TL, 1'b1, 4'h9, 6'o73);
    step();
    check("tail_idle", obs2, 8'h00);

    cur_tag = "local";
    drive(1'b1, HDR, 1'b0, 4'h5, 6'o30);
    step();
    check("local_d2", obs2, 8'b10000_100);
    check("west_d3", obs3, 8'b00100_100);
    drive(1'b1, PAY, 1'b1, 4'h5, 6'o30);
    step();
    step();
    check("payload_hold", obs2, 8'b10000_100);
    drive(1'b1, TL, 1'b1, 4'h5, 6'o30);
    step();
    check("tail_clear", obs2, 8'h00);
    drive(1'b0, 3'b000, 1'b1, 4'h5, 6'o30);
    step();

    cur_tag = "deroute";
    do_reset(8'h3C, 4'hC, 8'h02, 4'h5, 6'o33);
    drive(1'b1, HDR, 1'b0, 4'h2, 6'o33);
    step();
    check("deroute_w", obs2, 8'b00100_100);
    drive(1'b1, TL, 1'b1, 4'h2, 6'o33);
    step();

    cur_tag = "unroutable";
    do_reset(8'h3C, 4'h8, 8'h02, 4'h5, 6'o33);
    drive(1'b1, HDR, 1'b0, 4'h2, 6'o33);
    for (int i = 0; i < 3; i++) begin
      step();
      check("unroutable", obs2, 8'b00000_010);
    end

    cur_tag = "hold";
    drive(1'b0, 3'b000, 1'b0, 4'h0, 6'o33);
    do_reset(8'h3C, 4'hF, 8'h00, 4'h5, 6'o33);
    drive(1'b1, HDR, 1'b0, 4'h9, 6'o33);
    step();
    drive(1'b0, 3'b000, 1'b1, 4'h9, 6'o33);
    for (int i = 0; i < 5; i++) step();
    check("empty_hold", obs2, 8'b01000_100);
    drive(1'b1, HDR, 1'b0, 4'h6, 6'o33);
    step();
    check("reroute_proto", obs2, 8'b00010_101);
    drive(1'b1, PAY, 1'b0, 4'h6, 6'o33);
    step();
    check("proto_pulse_end", obs2, 8'b00010_100);

    cur_tag = "mid_rst";
    do_reset(8'h00, 4'hF, 8'h00, 4'h0, 6'o00);
    check("mid_rst_clear", obs2, 8'h00);
    drive(1'b1, HDR, 1'b0, 4'hF, 6'o00);
    step();
    check("new_cfg_north", obs2, 8'b00001_100);

    cur_tag = "single";
    drive(1'b1, TL, 1'b1, 4'hF, 6'o00);
    step();
    drive(1'b1, SGL, 1'b0, 4'h0, 6'o00);
    step();
    check("single_route", obs2, 8'b10000_100);
    drive(1'b1, SGL, 1'b1, 4'h0, 6'o00);
    step();
    check("single_done", obs2, 8'h00);
    drive(1'b0, TL, 1'b1, 4'h0, 6'o00);
    step();
    check("grant_no_valid", obs2, 8'h00);

    cur_tag = "random";
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        rxy_rst = 8'($urandom); cx_rst = 4'($urandom); dr_rst = 8'($urandom);
        cur2_rst = 4'($urandom); cur3_rst = 6'($urandom);
      end else begin
        rst = 1'b0;
      end
      drive($urandom_range(0, 4) != 0, ids[$urandom_range(0, 4)], 1'($urandom),
            4'($urandom), 6'($urandom));
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
